pipe_hazard_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage pipeline. Drives the enables of the PC and the
//  IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the IF/ID and ID/EX bubble flushes.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_e;

  localparam int unsigned DEF_REG_W = 5;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID-stage sources and the EX-stage load destination.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = DEF_REG_W
) (
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_regdst_i,
  output logic             load_use_o
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency
  always_comb begin
    load_use_o = ex_memread_i && (ex_regdst_i != '0) &&
                 ((ex_regdst_i == id_rs_i) || (id_uses_rt_i && (ex_regdst_i == id_rt_i)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch/jump squashes, dmem freeze and watchdog halt.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W       = DEF_REG_W,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_regdst,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               timeout_q, timeout_d;
  logic               load_use;
  logic               freeze;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rt_i (id_uses_rt),
    .ex_memread_i (ex_memread),
    .ex_regdst_i  (ex_regdst),
    .load_use_o   (load_use)
  );

  assign freeze = mem_req && !mem_ack;

  // Outputs are gated by rst directly so an asynchronous reset blanks them immediately
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst || (state_q == HALT) || freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    stall_d   = stall_q;
    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = MEMWAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEMWAIT: begin
        if (!freeze) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      HALT: ;
      default: state_d = RUN;
    endcase
    if (!pc_en && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised bench for pipe_hazard_ctrl with a behavioural model plus directed literal checks.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned TMO     = 4;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             ck = 1'b0;
  logic             rst = 1'b1;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_regdst = '0;
  logic             id_uses_rt = 1'b0, id_jump = 1'b0, ex_memread = 1'b0;
  logic             ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .ck(ck), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_memread(ex_memread), .ex_regdst(ex_regdst),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 ck = ~ck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: halted flag, length of the current unacked run, pc-stall tally
  bit          m_halted = 1'b0;
  int unsigned m_waits  = 0;
  int unsigned m_cnt    = 0;

  always @(negedge ck) begin
    bit       lu, frz;
    logic [4:0] en_x;
    logic [1:0] fl_x;
    lu  = ex_memread && (ex_regdst != 0) &&
          (ex_regdst == id_rs || (id_uses_rt && ex_regdst == id_rt));
    frz = mem_req && !mem_ack;
    if (rst || m_halted || frz) begin en_x = 5'b00000; fl_x = 2'b00; end
    else if (ex_branch_taken)   begin en_x = 5'b11111; fl_x = 2'b11; end
    else if (lu)                begin en_x = 5'b00111; fl_x = 2'b01; end
    else if (id_jump)           begin en_x = 5'b11111; fl_x = 2'b10; end
    else                        begin en_x = 5'b11111; fl_x = 2'b00; end
    chk("enables", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, en_x});
    chk("flushes", {30'd0, ifid_flush, idex_flush}, {30'd0, fl_x});
    chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, (!rst && m_halted)});
    chk("stall_cnt", {27'd0, stall_cnt}, rst ? 32'd0 : m_cnt);
    if (rst) begin
      m_halted = 1'b0;
      m_waits  = 0;
      m_cnt    = 0;
    end else begin
      if (!en_x[4] && m_cnt < CNT_MAX) m_cnt++;
      if (!m_halted) begin
        m_waits = frz ? m_waits + 1 : 0;
        if (m_waits == TMO + 1) m_halted = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic idle();
    ex_memread = 0; ex_regdst = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    id_jump = 0; ex_branch_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  initial begin
    bit mem_busy;
    mem_busy = 0;

    cyc(); #3;
    chk("reset_pc_en", {31'd0, pc_en}, 32'd0);
    chk("reset_stall", {27'd0, stall_cnt}, 32'd0);
    cyc(); rst = 0; idle();
    cyc();

    // load-use single bubble
    cyc(); ex_memread = 1; ex_regdst = 5; id_rs = 5; #3;
    chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
    chk("lu_ifid_en", {31'd0, ifid_en}, 32'd0);
    chk("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
    chk("lu_idex_en", {31'd0, idex_en}, 32'd1);
    cyc(); idle(); #3;
    chk("lu_stall_cnt", {27'd0, stall_cnt}, 32'd1);

    // no hazard: r0 destination, rt not read
    cyc(); ex_memread = 1; ex_regdst = 0; id_rs = 0; #3;
    chk("r0_no_stall", {31'd0, pc_en}, 32'd1);
    cyc(); ex_regdst = 5; id_rs = 1; id_rt = 5; id_uses_rt = 0; #3;
    chk("rt_unused_no_stall", {31'd0, pc_en}, 32'd1);
    cyc(); id_uses_rt = 1; #3;
    chk("rt_used_stall", {31'd0, pc_en}, 32'd0);

    // branch beats load-use
    cyc(); id_rs = 5; ex_branch_taken = 1; #3;
    chk("br_lu_flush", {30'd0, ifid_flush, idex_flush}, 32'd3);
    chk("br_lu_pc_en", {31'd0, pc_en}, 32'd1);
    cyc(); idle();

    // three-cycle memory wait with branch held
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_req = 1; mem_ack = 0; ex_branch_taken = 1; #3;
      chk("wait_memwb_en", {31'd0, memwb_en}, 32'd0);
      chk("wait_no_flush", {31'd0, ifid_flush}, 32'd0);
    end
    cyc(); mem_ack = 1; #3;
    chk("ack_all_en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'h1f);
    chk("ack_flush", {31'd0, ifid_flush}, 32'd1);
    cyc(); idle();

    // watchdog: ack never arrives
    for (int i = 0; i < 5; i++) begin
      cyc(); mem_req = 1; mem_ack = 0; #3;
      chk("tmo_not_yet", {31'd0, mem_timeout}, 32'd0);
    end
    cyc(); mem_ack = 1; #3;
    chk("tmo_fired", {31'd0, mem_timeout}, 32'd1);
    chk("halt_ignores_ack", {31'd0, pc_en}, 32'd0);
    repeat (40) cyc();
    #3;
    chk("stall_saturate", {27'd0, stall_cnt}, CNT_MAX);
    cyc(); rst = 1; #3;
    chk("rst_clears_tmo", {31'd0, mem_timeout}, 32'd0);
    cyc(); rst = 0; idle(); #3;
    chk("rst_run", {31'd0, pc_en}, 32'd1);

    // asynchronous reset mid-wait
    cyc(); mem_req = 1;
    cyc(); cyc();
    #1 rst = 1;
    #1;
    chk("async_rst_en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'd0);
    chk("async_rst_cnt", {27'd0, stall_cnt}, 32'd0);
    cyc(); rst = 0; idle(); #3;
    chk("post_rst_run", {31'd0, pc_en}, 32'd1);

    // randomised traffic; dmem requests persist until acknowledged
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst = ($urandom_range(0, 39) == 0);
      if (rst) mem_busy = 0;
      ex_memread      = ($urandom_range(0, 2) == 0);
      ex_regdst       = REG_W'($urandom_range(0, 3));
      id_rs           = REG_W'($urandom_range(0, 3));
      id_rt           = REG_W'($urandom_range(0, 3));
      id_uses_rt      = $urandom_range(0, 1) == 1;
      id_jump         = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      if (!mem_busy) mem_busy = ($urandom_range(0, 3) == 0);
      mem_req = mem_busy;
      mem_ack = mem_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      if (mem_ack) mem_busy = 0;
    end
    cyc(); idle();
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
